// File: rtl/quadratura_pkg.sv
`default_nettype none
// ============================================================================
// Module   : quadratura_pkg
// Purpose  : Shared definitions for the quadrature decoder: 2-bit phase
//            constants {A,B}, decoder FSM states, filter counter width and
//            helpers that give the next phase in each direction.
// Revision : 1.0 - initial release
// ============================================================================
package quadratura_pkg;

  // Phase word is {A,B}
  localparam logic [1:0] FASE_00 = 2'b00;
  localparam logic [1:0] FASE_10 = 2'b10;
  localparam logic [1:0] FASE_11 = 2'b11;
  localparam logic [1:0] FASE_01 = 2'b01;

  // Width of the per-channel stability counter (holds up to 15)
  localparam int CONT_W = 4;

  typedef enum logic {
    INICIAL = 1'b0,
    ATIVO   = 1'b1
  } estado_t;

  // Forward (A leads B): 00 -> 10 -> 11 -> 01 -> 00
  function automatic logic [1:0] passo_frente(input logic [1:0] fase);
    logic [1:0] prox;
    case (fase)
      FASE_00: prox = FASE_10;
      FASE_10: prox = FASE_11;
      FASE_11: prox = FASE_01;
      default: prox = FASE_00;
    endcase
    return prox;
  endfunction

  // Reverse (B leads A): 00 -> 01 -> 11 -> 10 -> 00
  function automatic logic [1:0] passo_tras(input logic [1:0] fase);
    logic [1:0] prox;
    case (fase)
      FASE_00: prox = FASE_01;
      FASE_01: prox = FASE_11;
      FASE_11: prox = FASE_10;
      default: prox = FASE_00;
    endcase
    return prox;
  endfunction

endpackage
`default_nettype wire

// File: rtl/filtro_entrada.sv
`default_nettype none
// ============================================================================
// Module   : filtro_entrada
// Purpose  : One encoder channel input path: 2-FF synchronizer followed, when
//            QUAD_FILTER_EN is defined, by a stability filter that only moves
//            its output after FILTRO_CICLOS identical consecutive samples
//            differing from the current value.
// Ports    : clk     - clock
//            rst_n   - asynchronous active-low reset
//            entrada - raw asynchronous channel input
//            saida   - synchronized (and optionally filtered) channel value
//            valido  - high once saida carries a real post-reset sample
// Config   : QUAD_FILTER_EN - enables the stability filter
// Revision : 1.0 - initial release
// ============================================================================
module filtro_entrada
  import quadratura_pkg::*;
#(
  parameter int FILTRO_CICLOS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic entrada,
  output logic saida,
  output logic valido
);

  if (FILTRO_CICLOS < 1 || FILTRO_CICLOS > 15) begin : g_param_invalido
    $error("filtro_entrada: FILTRO_CICLOS must be within 1..15");
  end

  logic       sync_q1;
  logic       sync_q2;
  // Tracks how far real samples have travelled through the synchronizer,
  // so the decoder never treats the reset value of the flops as a phase.
  logic [1:0] sync_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1  <= 1'b0;
      sync_q2  <= 1'b0;
      sync_vld <= 2'b00;
    end else begin
      sync_q1  <= entrada;
      sync_q2  <= sync_q1;
      sync_vld <= {sync_vld[0], 1'b1};
    end
  end

`ifdef QUAD_FILTER_EN
  localparam logic [CONT_W-1:0] LIMITE = CONT_W'(FILTRO_CICLOS - 1);

  logic [CONT_W-1:0] contador;
  logic              filtrado;
  logic              carregado;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      contador  <= '0;
      filtrado  <= 1'b0;
      carregado <= 1'b0;
    end else if (!carregado) begin
      // The first valid sample is taken as-is so an encoder resting at 1
      // does not have to "prove" itself against the reset value.
      contador <= '0;
      if (sync_vld[1]) begin
        filtrado  <= sync_q2;
        carregado <= 1'b1;
      end
    end else if (sync_q2 == filtrado) begin
      // Glitch back to the current value restarts the run
      contador <= '0;
    end else if (contador == LIMITE) begin
      filtrado <= sync_q2;
      contador <= '0;
    end else begin
      contador <= contador + 1'b1;
    end
  end

  assign saida  = filtrado;
  assign valido = carregado;
`else
  assign saida  = sync_q2;
  assign valido = sync_vld[1];
`endif

endmodule
`default_nettype wire

// File: rtl/decodificador_quadratura.sv
`default_nettype none
// ============================================================================
// Module   : decodificador_quadratura
// Purpose  : x4 quadrature decoder. Turns asynchronous A/B encoder channels
//            into one-cycle increment/decrement strobes and flags illegal
//            double-edge transitions.
// Ports    : clk      - clock, rising edge active
//            rst_n    - asynchronous active-low reset
//            canal_a  - encoder channel A (asynchronous)
//            canal_b  - encoder channel B (asynchronous)
//            acrescer - one-cycle increment strobe (registered)
//            decrecer - one-cycle decrement strobe (registered)
//            erro     - one-cycle illegal-transition strobe (registered)
// Config   : QUAD_FILTER_EN - enables the per-channel stability filter
// Revision : 1.0 - initial release
// ============================================================================
module decodificador_quadratura
  import quadratura_pkg::*;
#(
  parameter int FILTRO_CICLOS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic canal_a,
  input  logic canal_b,
  output logic acrescer,
  output logic decrecer,
  output logic erro
);

  logic       a_filt;
  logic       b_filt;
  logic       a_valido;
  logic       b_valido;
  logic [1:0] fase;

  filtro_entrada #(
    .FILTRO_CICLOS (FILTRO_CICLOS)
  ) u_filtro_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .entrada (canal_a),
    .saida   (a_filt),
    .valido  (a_valido)
  );

  filtro_entrada #(
    .FILTRO_CICLOS (FILTRO_CICLOS)
  ) u_filtro_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .entrada (canal_b),
    .saida   (b_filt),
    .valido  (b_valido)
  );

  assign fase = {a_filt, b_filt};

  estado_t    estado;
  estado_t    estado_n;
  logic [1:0] fase_ant;
  logic [1:0] fase_ant_n;
  logic       acrescer_n;
  logic       decrecer_n;
  logic       erro_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado   <= INICIAL;
      fase_ant <= FASE_00;
      acrescer <= 1'b0;
      decrecer <= 1'b0;
      erro     <= 1'b0;
    end else begin
      estado   <= estado_n;
      fase_ant <= fase_ant_n;
      acrescer <= acrescer_n;
      decrecer <= decrecer_n;
      erro     <= erro_n;
    end
  end

  always_comb begin
    estado_n   = estado;
    fase_ant_n = fase_ant;
    acrescer_n = 1'b0;
    decrecer_n = 1'b0;
    erro_n     = 1'b0;
    case (estado)
      INICIAL: begin
        // Seed the reference phase silently so a non-00 resting position
        // after reset does not look like a transition.
        if (a_valido && b_valido) begin
          fase_ant_n = fase;
          estado_n   = ATIVO;
        end
      end
      ATIVO: begin
        fase_ant_n = fase;
        if (fase == fase_ant) begin
          // no movement
        end else if (fase == passo_frente(fase_ant)) begin
          acrescer_n = 1'b1;
        end else if (fase == passo_tras(fase_ant)) begin
          decrecer_n = 1'b1;
        end else begin
          // Both bits moved at once: direction is unknowable
          erro_n = 1'b1;
        end
      end
      default: begin
        estado_n = INICIAL;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_decodificador_quadratura.sv
`default_nettype none
// ============================================================================
// Module   : tb_decodificador_quadratura
// Purpose  : Directed self-checking bench for decodificador_quadratura.
//            Outputs are sampled on the falling edge; inputs also change on
//            the falling edge, so a change is captured by the next rising
//            edge and the strobe appears after LAT rising edges.
// Config   : QUAD_FILTER_EN - adds the glitch-filter steps and longer latency
// Revision : 1.0 - initial release
// ============================================================================
module tb_decodificador_quadratura;
  import quadratura_pkg::*;

`ifdef QUAD_FILTER_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 3;
`endif

  logic clk;
  logic rst_n;
  logic canal_a;
  logic canal_b;
  logic acrescer;
  logic decrecer;
  logic erro;

  int         verif;
  int         falhas;
  logic [7:0] contador;

  decodificador_quadratura #(
    .FILTRO_CICLOS (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .canal_a  (canal_a),
    .canal_b  (canal_b),
    .acrescer (acrescer),
    .decrecer (decrecer),
    .erro     (erro)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare {acrescer,decrecer,erro} and track a downstream 8-bit counter
  task automatic verifica(input string tag, input logic [2:0] esperado);
    logic [2:0] obs;
    obs = {acrescer, decrecer, erro};
    verif++;
    assert (obs === esperado) else begin
      falhas++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, esperado);
    end
    if (obs[2]) contador = contador + 8'd1;
    if (obs[1]) contador = contador - 8'd1;
  endtask

  task automatic verifica_estado(input string tag, input estado_t esperado);
    verif++;
    assert (dut.estado === esperado) else begin
      falhas++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, dut.estado, esperado);
    end
  endtask

  task automatic verifica_contador(input string tag, input logic [7:0] esperado);
    verif++;
    assert (contador === esperado) else begin
      falhas++;
      $error("FAIL %s: observed=%h expected=%h", tag, contador, esperado);
    end
  endtask

  // Apply a phase at the current falling edge and watch 10 cycles: only
  // the LAT-th sample may carry a strobe, and only for one cycle.
  task automatic passo(input logic [1:0] f, input logic [2:0] esperado, input string tag);
    {canal_a, canal_b} = f;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      verifica($sformatf("%s c%0d", tag, i), (i == LAT) ? esperado : 3'b000);
    end
  endtask

  initial begin
    verif    = 0;
    falhas   = 0;
    contador = 8'h00;
    rst_n    = 1'b0;
    canal_a  = 1'b1;
    canal_b  = 1'b1;

    // Reset held with encoder resting at 11
    repeat (3) @(negedge clk);
    verifica("reset saidas", 3'b000);
    verifica_estado("reset estado", INICIAL);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      verifica("estatico 11", 3'b000);
    end
    verifica_estado("estado ativo", ATIVO);

    // Walk forward from 11 back to 00
    passo(FASE_01, 3'b100, "11->01");
    passo(FASE_00, 3'b100, "01->00");

    // Forward cycle
    contador = 8'h6A;
    passo(FASE_10, 3'b100, "fwd 00->10");
    passo(FASE_11, 3'b100, "fwd 10->11");
    passo(FASE_01, 3'b100, "fwd 11->01");
    passo(FASE_00, 3'b100, "fwd 01->00");
    verifica_contador("contador fwd", 8'h6E);

    // Reverse, two full cycles, wraps below zero
    contador = 8'h03;
    for (int r = 0; r < 2; r++) begin
      passo(FASE_01, 3'b010, "rev 00->01");
      passo(FASE_11, 3'b010, "rev 01->11");
      passo(FASE_10, 3'b010, "rev 11->10");
      passo(FASE_00, 3'b010, "rev 10->00");
    end
    verifica_contador("contador rev", 8'hFB);

    // Illegal jump, then a legal step from the new phase
    contador = 8'h10;
    passo(FASE_11, 3'b001, "erro 00->11");
    verifica_contador("contador erro", 8'h10);
    passo(FASE_01, 3'b100, "apos erro 11->01");

    // Reset while a strobe is high: must drop immediately
    {canal_a, canal_b} = FASE_00;
    for (int i = 1; i <= LAT; i++) begin
      @(negedge clk);
      verifica($sformatf("pre-reset c%0d", i), (i == LAT) ? 3'b100 : 3'b000);
    end
    rst_n = 1'b0;
    #1;
    verifica("reset assincrono", 3'b000);
    repeat (3) @(negedge clk);
    verifica("durante reset", 3'b000);
    verifica_estado("reset meio", INICIAL);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      verifica("pos reset 00", 3'b000);
    end
    passo(FASE_10, 3'b100, "pos reset 00->10");

`ifdef QUAD_FILTER_EN
    passo(FASE_00, 3'b010, "filtro 10->00");
    // Two-cycle glitch on A must be swallowed
    canal_a = 1'b1;
    repeat (2) @(negedge clk);
    canal_a = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      verifica("glitch A", 3'b000);
    end
    passo(FASE_10, 3'b100, "filtro 00->10");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", verif, falhas);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/decodificador_quadratura.md
# decodificador_quadratura

Quadrature decoder for incremental encoder inputs. It turns the asynchronous A/B channel pair into single-cycle `acrescer`/`decrecer` strobes for the downstream 8-bit up/down counter, which steps once per strobe. The decoder uses x4 decoding: every legal edge on A or B yields exactly one strobe. Illegal double-edges are flagged on `erro` and never produce a count.

## Interface
- `FILTRO_CICLOS`, default 4: consecutive identical synchronized samples required before the filtered A/B value updates. Legal range is 1–15. Used only when `QUAD_FILTER_EN` is defined.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset; release is synchronous to `clk`.
- `canal_a` input 1: encoder channel A; asynchronous to `clk`.
- `canal_b` input 1: encoder channel B; asynchronous to `clk`.
- `acrescer` output 1: one-cycle increment strobe; registered.
- `decrecer` output 1: one-cycle decrement strobe; registered.
- `erro` output 1: one-cycle illegal-transition strobe; registered.

## Operation
- Input path: `canal_a`/`canal_b` → 2-FF synchronizer → optional filter → decoder.
- Phase word `fase = {A,B}` is 2 bits.
- Forward sequence: 00→10→11→01→00 (A leads B). Each forward step → `acrescer`=1 for one cycle.
- Reverse sequence: 00→01→11→10→00. Each reverse step → `decrecer`=1 for one cycle.
- No change in `fase` → no strobe.
- Both bits changed (00↔11 or 10↔01) → `erro`=1 for one cycle, no count strobe. `fase_ant` still updates to the new value.
- `acrescer` and `decrecer` are mutually exclusive by construction; at most one of the three outputs is high in any cycle.
- Decoder FSM has two states:
  - INICIAL (after reset): the first filtered sample is loaded into `fase_ant`, no strobe is issued, and the FSM moves to ATIVO. This prevents a false strobe or `erro` when the encoder rests at a non-00 phase during reset.
  - ATIVO: compare filtered `fase` against `fase_ant` every cycle, emit at most one strobe, then update `fase_ant`.
- Reset values: `acrescer`=0, `decrecer`=0, `erro`=0, synchronizer flops 0, `fase_ant`=00, filter counter 0, state INICIAL.
- Reset asserted mid-operation: all outputs drop asynchronously to 0 and any strobe in flight is discarded. After release the block re-enters INICIAL.

## Timing
- Without filter:
  - An input change captured at edge k reaches the synchronizer output at edge k+1.
  - The decoder registers the strobe at edge k+2, so the strobe is high from edge k+2 to k+3.
  - Latency is 2 edges from capture, 3 from the asynchronous change (worst case).
- With filter: add `FILTRO_CICLOS` edges. The filtered value updates on the edge where the same synchronized value has been seen `FILTRO_CICLOS` consecutive times.
- Maximum legal input rate: one phase change per (3 + `FILTRO_CICLOS`) cycles with the filter, one per 2 cycles without. Faster changes may merge into an `erro`.
- INICIAL → ATIVO takes exactly one edge after the first post-reset filtered sample is valid.

## Configuration
- `QUAD_FILTER_EN` defined:
  - A 4-bit per-channel stability counter filters the synchronized A and B.
  - A filtered bit changes only after `FILTRO_CICLOS` identical consecutive samples that differ from its current value.
  - Any intermediate glitch resets that channel's counter.
- `QUAD_FILTER_EN` undefined: no filter logic; the synchronizer output feeds the decoder directly and `FILTRO_CICLOS` is ignored.

## Structure
- Shared package `quadratura_pkg`:
  - 2-bit phase constants `FASE_00`, `FASE_10`, `FASE_11`, `FASE_01`.
  - FSM state enum {INICIAL, ATIVO}.
  - Filter counter width constant (4).
- One natural sub-module, `filtro_entrada`: per-channel 2-FF synchronizer plus optional stability filter. Instantiate it twice, once for A and once for B.
- Decode logic and FSM stay in the top module.

## Test plan
- Reset with A=1, B=1 held, then release, inputs static for 20 cycles → no `acrescer`, `decrecer` or `erro` strobes; FSM reaches ATIVO.
- Forward cycle 00→10→11→01→00, 10 cycles per step, filter off → exactly 4 `acrescer` pulses, each 1 cycle wide, each 3 edges after its input change. A downstream counter reset to 0x6A reads 0x6E.
- Reverse cycle from 00, 8 steps → exactly 8 `decrecer` pulses; a counter starting at 0x03 wraps to 0xFB.
- Jump 00→11 → one `erro` pulse and no count strobe. Then 11→01 → one `acrescer` pulse.
- With `QUAD_FILTER_EN` and `FILTRO_CICLOS`=4: 2-cycle glitch on A → no strobe. A held high 10 cycles → one `acrescer` pulse, 7 edges after the change.
- Assert `rst_n` during the cycle a strobe would issue → strobe suppressed and outputs 0 immediately. After release, the next legal step produces exactly one correct strobe.
